perc_mac_acc: RTL and testbench

Streaming multiply-accumulate stage of the perceptron pipeline, directly upstream of the arithmetic right-shift normaliser.
- Accepts one signed input/weight pair per beat and accumulates a frame (one neuron) on top of a bias.
- At the end of the frame, produces a saturated 16-bit sum plus its sign and the frame's shift amount. These drive the shifter's `x`, `sign` and `sel` inputs directly.
- Uses valid/ready handshakes on both sides, so it can stall behind downstream back-pressure.

---
 rtl/perc_pkg.sv | 32 +++
 rtl/perc_sat.sv | 25 ++
 rtl/perc_mac_acc.sv | 106 ++++++++++
 tb/tb_perc_mac_acc.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/perc_pkg.sv
// Shared constants, FSM state type and saturation bounds for the perceptron MAC stage.
package perc_pkg;

  localparam int unsigned D_WIDTH    = 16;
  localparam int unsigned SEL_WIDTH  = 6;
  localparam int unsigned IN_WIDTH   = 8;
  localparam int unsigned ACC_WIDTH  = 20;
  localparam int unsigned PROD_WIDTH = 2 * IN_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  // Accumulator clamp bounds
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Output narrowing bounds, expressed at accumulator width and at output width
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'({1'b0, {(D_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;
  localparam logic [D_WIDTH-1:0]          SAT_POS = {1'b0, {(D_WIDTH-1){1'b1}}};
  localparam logic [D_WIDTH-1:0]          SAT_NEG = {1'b1, {(D_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [D_WIDTH-1:0]   data;
    logic [SEL_WIDTH-1:0] sel;
    logic                 ovf;
  } result_t;

endpackage

// File: rtl/perc_sat.sv
// Combinational signed saturating narrower from accumulator width to output width.
module perc_sat
  import perc_pkg::*;
(
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [D_WIDTH-1:0]   sat_c,
  output logic                 ovf_c
);

  logic signed [ACC_WIDTH-1:0] acc_s;
  assign acc_s = acc;

  always_comb begin
    sat_c = acc[D_WIDTH-1:0];
    ovf_c = 1'b0;
    if (acc_s > OUT_MAX) begin
      sat_c = SAT_POS;
      ovf_c = 1'b1;
    end else if (acc_s < OUT_MIN) begin
      sat_c = SAT_NEG;
      ovf_c = 1'b1;
    end
  end

endmodule

// File: rtl/perc_mac_acc.sv
// Streaming signed multiply-accumulate over one frame on top of a bias, with a
// saturated, held result handed to the downstream shifter via valid/ready.
module perc_mac_acc
  import perc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SEL_WIDTH-1:0] cfg_shift,
  input  logic [D_WIDTH-1:0]   bias,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_x,
  input  logic [IN_WIDTH-1:0]  in_w,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [D_WIDTH-1:0]   out_data,
  output logic                 out_sign,
  output logic [SEL_WIDTH-1:0] out_sel,
  output logic                 out_ovf
);

  state_t                      state;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic                        ovf_q;
  logic [SEL_WIDTH-1:0]        sel_q;
  result_t                     res_q;

  logic signed [IN_WIDTH-1:0]   x_s, w_s;
  logic signed [D_WIDTH-1:0]    bias_s;
  logic signed [PROD_WIDTH-1:0] prod_c;
  logic signed [ACC_WIDTH-1:0]  base_c;
  logic signed [ACC_WIDTH:0]    sum_c;
  logic signed [ACC_WIDTH-1:0]  acc_next_c;
  logic                         acc_ovf_c;
  logic                         first_c;
  logic                         beat_c;
  logic                         sticky_next_c;
  logic [SEL_WIDTH-1:0]         sel_next_c;
  logic [D_WIDTH-1:0]           sat_data_c;
  logic                         sat_ovf_c;

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state == ST_FULL);
  assign out_data  = res_q.data;
  assign out_sign  = res_q.data[D_WIDTH-1];
  assign out_sel   = res_q.sel;
  assign out_ovf   = res_q.ovf;

  assign first_c = (state == ST_IDLE);
  assign beat_c  = in_valid && in_ready;

  // One extra sum bit exposes accumulator overflow as a top-two-bit mismatch
  assign x_s        = in_x;
  assign w_s        = in_w;
  assign bias_s     = bias;
  assign prod_c     = PROD_WIDTH'(x_s) * PROD_WIDTH'(w_s);
  assign base_c     = first_c ? ACC_WIDTH'(bias_s) : acc_q;
  assign sum_c      = (ACC_WIDTH+1)'(base_c) + (ACC_WIDTH+1)'(prod_c);
  assign acc_ovf_c  = sum_c[ACC_WIDTH] ^ sum_c[ACC_WIDTH-1];
  assign acc_next_c = acc_ovf_c ? (sum_c[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                                : sum_c[ACC_WIDTH-1:0];

  assign sticky_next_c = (first_c ? 1'b0 : ovf_q) | acc_ovf_c;
  assign sel_next_c    = first_c ? cfg_shift : sel_q;

  perc_sat u_sat (
    .acc   (acc_next_c),
    .sat_c (sat_data_c),
    .ovf_c (sat_ovf_c)
  );

  // FSM plus datapath registers; the result is only written on the last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc_q <= '0;
      ovf_q <= 1'b0;
      sel_q <= '0;
      res_q <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_ACC: begin
          if (beat_c) begin
            acc_q <= acc_next_c;
            ovf_q <= sticky_next_c;
            sel_q <= sel_next_c;
            if (in_last) begin
              res_q.data <= sat_data_c;
              res_q.sel  <= sel_next_c;
              res_q.ovf  <= sticky_next_c | sat_ovf_c;
              state      <= ST_FULL;
            end else begin
              state <= ST_ACC;
            end
          end
        end
        ST_FULL: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perc_mac_acc.sv
// Self-checking bench for perc_mac_acc against an integer frame model.
module tb_perc_mac_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  cfg_shift;
  logic [15:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [7:0]  in_w;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sign;
  logic [5:0]  out_sel;
  logic        out_ovf;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int qx[$];
  int qw[$];

  always #5 clk = ~clk;

  perc_mac_acc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_shift (cfg_shift),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sign  (out_sign),
    .out_sel   (out_sel),
    .out_ovf   (out_ovf)
  );

  // Frame reference: integer accumulate with clamping at +/-2^19, then narrow to 16 bits
  function automatic void model(input int b, output logic [15:0] d, output bit ovf);
    longint acc;
    acc = b;
    ovf = 1'b0;
    foreach (qx[i]) begin
      acc = acc + longint'(qx[i]) * longint'(qw[i]);
      if (acc > 524287) begin acc = 524287; ovf = 1'b1; end
      if (acc < -524288) begin acc = -524288; ovf = 1'b1; end
    end
    if (acc > 32767) begin d = 16'h7FFF; ovf = 1'b1; end
    else if (acc < -32768) begin d = 16'h8000; ovf = 1'b1; end
    else d = 16'(acc);
  endfunction

  task automatic run_frame(input int b, input int sh, input bit gaps, input int stall,
                           input bit early, input string tag);
    logic [15:0] ed;
    bit          eo;
    model(b, ed, eo);
    out_ready = early;
    for (int i = 0; i < qx.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_x     = 8'($urandom);
        @(posedge clk); #1;
      end
      in_valid  = 1'b1;
      in_x      = 8'(qx[i]);
      in_w      = 8'(qw[i]);
      in_last   = (i == qx.size() - 1);
      bias      = (i == 0) ? 16'(b) : 16'($urandom);
      cfg_shift = (i == 0) ? 6'(sh) : 6'($urandom);
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL %s in_ready beat %0d: got %b want 1", tag, i, in_ready);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL %s out_valid latency: got %b want 1", tag, out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== ed) $display("FAIL %s out_data: got %h want %h", tag, out_data, ed);
    else pass_cnt++;
    total_cnt++;
    if (out_sign !== ed[15]) $display("FAIL %s out_sign: got %b want %b", tag, out_sign, ed[15]);
    else pass_cnt++;
    total_cnt++;
    if (out_sel !== 6'(sh)) $display("FAIL %s out_sel: got %0d want %0d", tag, out_sel, sh);
    else pass_cnt++;
    total_cnt++;
    if (out_ovf !== eo) $display("FAIL %s out_ovf: got %b want %b", tag, out_ovf, eo);
    else pass_cnt++;
    out_ready = (stall == 0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== ed)
        $display("FAIL %s stall %0d: valid=%b ready=%b data=%h want 1/0/%h",
                 tag, s, out_valid, in_ready, out_data, ed);
      else pass_cnt++;
      if (s == stall - 1) out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL %s out_valid drop: got %b want 0", tag, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_x = '0; in_w = '0; bias = '0; cfg_shift = '0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0 || out_sel !== 6'h0 ||
        out_ovf !== 1'b0 || out_sign !== 1'b0)
      $display("FAIL reset_state: valid=%b ready=%b data=%h sel=%0d ovf=%b sign=%b want 0/1/0/0/0/0",
               out_valid, in_ready, out_data, out_sel, out_ovf, out_sign);
    else pass_cnt++;
    rst_n = 1'b1;
    // Mid-frame reset
    in_valid = 1'b1; in_x = 8'd50; in_w = 8'd50; bias = 16'd5; in_last = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_midframe: valid=%b ready=%b want 0/1", out_valid, in_ready);
    else pass_cnt++;
    rst_n = 1'b1;
    // Reset while holding a result
    in_valid = 1'b1; in_x = 8'd7; in_w = 8'd9; bias = 16'd1; cfg_shift = 6'd3; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 16'd64)
      $display("FAIL reset_prefill: valid=%b data=%0d want 1/64", out_valid, out_data);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0 || out_sel !== 6'h0 ||
        out_ovf !== 1'b0 || out_sign !== 1'b0)
      $display("FAIL reset_full: valid=%b ready=%b data=%h sel=%0d ovf=%b want 0/1/0/0/0",
               out_valid, in_ready, out_data, out_sel, out_ovf);
    else pass_cnt++;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL reset_no_emit cycle %0d: got %b want 0", i, out_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_directed();
    qx = '{3};                 qw = '{-5};                run_frame(100, 2, 0, 0, 0, "single");
    qx = '{10, -20, 7, 127};   qw = '{10, 3, -7, 127};    run_frame(0, 5, 0, 0, 0, "four_beat");
    qx = '{127, 127};          qw = '{127, 127};          run_frame(32000, 1, 0, 0, 0, "pos_sat");
    qx = '{1};                 qw = '{1};                 run_frame(1, 0, 0, 0, 0, "after_sat");
    qx = '{-128};              qw = '{127};               run_frame(-32768, 17, 0, 0, 0, "neg_sat");
    qx = '{5, 6};              qw = '{5, 6};              run_frame(-7, 63, 0, 0, 1, "early_ready");
  endtask

  task automatic test_acc_clamp();
    qx.delete(); qw.delete();
    for (int i = 0; i < 33; i++) begin qx.push_back(127);  qw.push_back(127); end
    for (int i = 0; i < 32; i++) begin qx.push_back(-128); qw.push_back(127); end
    run_frame(0, 4, 0, 0, 0, "clamp_pos");
    qx.delete(); qw.delete();
    for (int i = 0; i < 33; i++) begin qx.push_back(-128); qw.push_back(127); end
    for (int i = 0; i < 32; i++) begin qx.push_back(127);  qw.push_back(127); end
    run_frame(0, 4, 1, 0, 0, "clamp_neg");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_x = 8'd100; in_w = 8'd100; bias = 16'd0; cfg_shift = 6'd3; in_last = 1'b1;
    @(posedge clk); #1;
    in_x = 8'd2; in_w = 8'd3; bias = 16'd10; cfg_shift = 6'd4; in_last = 1'b1;
    for (int s = 0; s < 5; s++) begin
      total_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'd10000 || out_sel !== 6'd3)
        $display("FAIL b2b_hold %0d: ready=%b valid=%b data=%0d sel=%0d want 0/1/10000/3",
                 s, in_ready, out_valid, out_data, out_sel);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL b2b_release: valid=%b ready=%b want 0/1", out_valid, in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== 16'd16 || out_sel !== 6'd4 || out_ovf !== 1'b0)
      $display("FAIL b2b_held_beat: valid=%b data=%0d sel=%0d ovf=%b want 1/16/4/0",
               out_valid, out_data, out_sel, out_ovf);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int f = 0; f < 30; f++) begin
      int n;
      n = int'($urandom_range(1, 24));
      qx.delete(); qw.delete();
      for (int i = 0; i < n; i++) begin
        qx.push_back(int'($urandom_range(0, 255)) - 128);
        qw.push_back(int'($urandom_range(0, 255)) - 128);
      end
      run_frame(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 63)),
                bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_acc_clamp();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
